redun_sq_seq: RTL
=================

Name: redun_sq_seq

Overview:
- Iteration sequencer for the redundant-form Montgomery squarer (`redun_mont`) inside the VDF core.
- Takes a start value and an iteration count T, then loops the squarer output back to its input T times. Returns the final value with a done pulse.
- Sits in the squarer clock domain, between the clock-crossing FIFOs and `redun_mont`.
- Adds abort, overflow trapping and a no-response watchdog.

Parameters:
- NUM_WRDS, 65, number of redundant words per operand (matches redun_mont_pkg).
- WRD_BITS, 16, bits per redundant word; only 16 and 32 are legal, anything else is a $fatal at elaboration.
- CNT_BITS, 40, width of the iteration counter and of i_iters.
- WD_CYC, 64, maximum cycles allowed between issuing a square and receiving its result.

Ports:
- i_clk  in  1  clock; squarer clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start request; honoured only in IDLE.
- i_sq_in  in  redun0_t  start value; sampled when i_start is accepted.
- i_iters  in  CNT_BITS  iteration count T; sampled when i_start is accepted.
- i_abort  in  1  abort the current run.
- o_busy  out  1  high from start acceptance until return to IDLE or ERR.
- o_done  out  1  one-cycle pulse when the final result is valid.
- o_sq_out  out  redun0_t  final result; held until the next accepted start.
- o_iter_cnt  out  CNT_BITS  number of completed squarings.
- o_err  out  2  error code: 0 none, 1 overflow, 2 watchdog; sticky until the next accepted start.
- o_mont_sq  out  redun0_t  operand to the squarer.
- o_mont_val  out  1  operand valid pulse to the squarer.
- i_mont_mul  in  redun0_t  squarer result.
- i_mont_val  in  1  squarer result valid.
- i_mont_ovf  in  1  squarer overflow flag; qualified by i_mont_val.

Behaviour:
- Reset: all outputs 0, o_sq_out 0, state IDLE, counters 0.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - On i_start, latch i_sq_in into the operand register and i_iters into the target; clear o_err and o_iter_cnt; set o_busy.
  - If i_iters == 0: go to DONE; o_sq_out = i_sq_in; o_done fires on the cycle after i_start.
  - Otherwise go to ISSUE.
- ISSUE: drive o_mont_val = 1 for exactly one cycle with o_mont_sq = operand register; clear the watchdog; go to WAIT.
- WAIT: the watchdog increments every cycle.
  - i_mont_val with i_mont_ovf = 1 → ERR, o_err = 1.
  - i_mont_val with i_mont_ovf = 0 → o_iter_cnt + 1 and operand register = i_mont_mul.
    - If the new count equals the target: o_sq_out = i_mont_mul, go to DONE.
    - Otherwise go to ISSUE.
  - Watchdog reaches WD_CYC with no i_mont_val → ERR, o_err = 2.
- DONE: o_done = 1 for one cycle, o_busy = 0, go to IDLE.
- ERR: o_busy = 0; stay until i_start, which is handled exactly as in IDLE.
- Loop timing: squarer latency L gives a period of L + 2 cycles per iteration (one cycle to register the result, one to issue).
- i_abort in ISSUE, WAIT or DONE: go to IDLE next cycle; o_busy = 0; no o_done; o_sq_out unchanged; o_iter_cnt holds the partial count.
- i_abort in IDLE or ERR has no effect.
- i_abort and i_start in the same cycle in IDLE: start wins.
- i_mont_val outside WAIT (stale result after an abort) is ignored, including i_mont_ovf.
- i_start while busy is ignored; the latched operands are not disturbed.
- i_iters = 2^CNT_BITS − 1: the counter must not wrap before the compare; completes normally.
- Only one square is ever outstanding at a time.

Optional Feature:
- Macro: REDUN_SQ_SEQ_CHKPT_EN.
- When defined, adds:
  - parameter CHKPT_INT, default 1024;
  - output o_chkpt_val (1 bit);
  - output o_chkpt (redun0_t).
- With the macro: every time o_iter_cnt becomes a nonzero multiple of CHKPT_INT, o_chkpt = i_mont_mul and o_chkpt_val pulses for one cycle, in the same cycle the count updates. No checkpoint fires for a final iteration that is also a multiple of CHKPT_INT; o_done covers it.
- Without the macro: those ports and that logic are absent; behaviour is otherwise identical.

Test Plan:
- Squarer model with latency 5, start value 3, i_iters = 4 → four o_mont_val pulses 7 cycles apart; o_done once; o_iter_cnt = 4; o_sq_out equals the model's fourth square; o_err = 0.
- i_iters = 0, i_start with value 0x1234 → o_done on the next cycle; o_sq_out = 0x1234; no o_mont_val.
- i_iters = 10, i_mont_ovf asserted with the third result → o_err = 1; o_iter_cnt = 2; no o_done; o_busy drops; a new start clears o_err.
- Model stops responding after iteration 1, WD_CYC = 64 → ERR 64 cycles after the second issue; o_err = 2.
- i_abort during WAIT of iteration 3, with the stale i_mont_val arriving 2 cycles later → IDLE; stale result ignored; a new start with T = 1 completes correctly.
- With REDUN_SQ_SEQ_CHKPT_EN, CHKPT_INT = 2, T = 5 → o_chkpt_val pulses at counts 2 and 4 with the matching values; o_done at 5.
- Async reset mid-WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/redun_sq_seq.sv
// redun_sq_seq: iteration sequencer for the redundant-form Montgomery squarer.
// Loads a start value and an iteration count T, then sends each squarer result
// back to the squarer as the next operand until T squarings have completed.
// Supports abort, overflow trapping and a no-response watchdog.
// Optional checkpoint outputs are enabled by defining REDUN_SQ_SEQ_CHKPT_EN.
module redun_sq_seq #(
    parameter int NUM_WRDS  = 65,
    parameter int WRD_BITS  = 16,
    parameter int CNT_BITS  = 40,
`ifdef REDUN_SQ_SEQ_CHKPT_EN
    parameter int CHKPT_INT = 1024,
`endif
    parameter int WD_CYC    = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [NUM_WRDS*WRD_BITS-1:0]   i_sq_in,
    input  logic [CNT_BITS-1:0]            i_iters,
    input  logic                           i_abort,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [NUM_WRDS*WRD_BITS-1:0]   o_sq_out,
    output logic [CNT_BITS-1:0]            o_iter_cnt,
    output logic [1:0]                     o_err,
    output logic [NUM_WRDS*WRD_BITS-1:0]   o_mont_sq,
    output logic                           o_mont_val,
    input  logic [NUM_WRDS*WRD_BITS-1:0]   i_mont_mul,
    input  logic                           i_mont_val,
`ifdef REDUN_SQ_SEQ_CHKPT_EN
    output logic                           o_chkpt_val,
    output logic [NUM_WRDS*WRD_BITS-1:0]   o_chkpt,
`endif
    input  logic                           i_mont_ovf
);

    localparam int DW  = NUM_WRDS * WRD_BITS;
    localparam int WDW = $clog2(WD_CYC + 1);

    // The squarer datapath only exists for 16- and 32-bit redundant words.
    if ((WRD_BITS != 16) && (WRD_BITS != 32)) begin : g_bad_wrd_bits
        $fatal(1, "redun_sq_seq: WRD_BITS must be 16 or 32");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              r_state;
    logic [DW-1:0]       r_op;
    logic [CNT_BITS-1:0] r_target;
    logic [WDW-1:0]      r_wd;
    logic                r_busy;
    logic                r_done;
    logic [DW-1:0]       r_sq_out;
    logic [CNT_BITS-1:0] r_iter_cnt;
    logic [1:0]          r_err;
    logic [DW-1:0]       r_mont_sq;
    logic                r_mont_val;

    // The count is widened by one bit so the terminal compare can never see a
    // wrapped value, even for T = 2^CNT_BITS - 1.
    logic [CNT_BITS:0]   w_cnt_nxt;
    logic                w_last;
    logic                w_wd_exp;

    assign w_cnt_nxt = {1'b0, r_iter_cnt} + {{CNT_BITS{1'b0}}, 1'b1};
    assign w_last    = (w_cnt_nxt == {1'b0, r_target});
    assign w_wd_exp  = (r_wd == WDW'(WD_CYC - 1));

`ifdef REDUN_SQ_SEQ_CHKPT_EN
    logic                r_chkpt_val;
    logic [DW-1:0]       r_chkpt;
    logic                w_chkpt_hit;

    assign w_chkpt_hit = ((w_cnt_nxt[CNT_BITS-1:0] % CNT_BITS'(CHKPT_INT)) == {CNT_BITS{1'b0}});
    assign o_chkpt_val = r_chkpt_val;
    assign o_chkpt     = r_chkpt;
`endif

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sq_out   = r_sq_out;
    assign o_iter_cnt = r_iter_cnt;
    assign o_err      = r_err;
    assign o_mont_sq  = r_mont_sq;
    assign o_mont_val = r_mont_val;

    // Sequencer FSM: start/abort handling, issue/wait loop, watchdog and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= {DW{1'b0}};
            r_target   <= {CNT_BITS{1'b0}};
            r_wd       <= {WDW{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sq_out   <= {DW{1'b0}};
            r_iter_cnt <= {CNT_BITS{1'b0}};
            r_err      <= 2'd0;
            r_mont_sq  <= {DW{1'b0}};
            r_mont_val <= 1'b0;
`ifdef REDUN_SQ_SEQ_CHKPT_EN
            r_chkpt_val <= 1'b0;
            r_chkpt     <= {DW{1'b0}};
`endif
        end else begin
            // Pulse outputs default low; the branches below raise them for one cycle.
            r_mont_val <= 1'b0;
            r_done     <= 1'b0;
`ifdef REDUN_SQ_SEQ_CHKPT_EN
            r_chkpt_val <= 1'b0;
`endif
            case (r_state)
                // ERR accepts a new start exactly like IDLE; abort is ignored in both.
                S_IDLE, S_ERR: begin
                    if (i_start) begin
                        r_op       <= i_sq_in;
                        r_target   <= i_iters;
                        r_err      <= 2'd0;
                        r_iter_cnt <= {CNT_BITS{1'b0}};
                        r_wd       <= {WDW{1'b0}};
                        r_busy     <= 1'b1;
                        if (i_iters == {CNT_BITS{1'b0}}) begin
                            r_sq_out <= i_sq_in;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_ISSUE;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_ISSUE: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_mont_sq  <= r_op;
                        r_mont_val <= 1'b1;
                        r_wd       <= {WDW{1'b0}};
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (i_mont_val) begin
                        if (i_mont_ovf) begin
                            r_err   <= 2'd1;
                            r_busy  <= 1'b0;
                            r_state <= S_ERR;
                        end else begin
                            r_iter_cnt <= w_cnt_nxt[CNT_BITS-1:0];
                            r_op       <= i_mont_mul;
                            if (w_last) begin
                                r_sq_out <= i_mont_mul;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end else begin
`ifdef REDUN_SQ_SEQ_CHKPT_EN
                                // The final iteration is reported by o_done, never by a checkpoint.
                                if (w_chkpt_hit) begin
                                    r_chkpt     <= i_mont_mul;
                                    r_chkpt_val <= 1'b1;
                                end else begin
                                    r_chkpt_val <= 1'b0;
                                end
`endif
                                r_state <= S_ISSUE;
                            end
                        end
                    end else if (w_wd_exp) begin
                        r_err   <= 2'd2;
                        r_busy  <= 1'b0;
                        r_state <= S_ERR;
                    end else begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
